// File: rtl/imm_extend_stage_pkg.sv
// Shared definitions for the immediate-extend stage.
//   ImmSrc_t      : immediate format selector. The original I/S/B/U/J
//                   encodings are kept; Z and SHAMT take the next free codes.
//                   Code 3'd7 is undefined and is flagged as illegal.
//   stage_state_t : occupancy of the two-entry output/skid buffer.
package imm_extend_stage_pkg;

  localparam int IMMSRC_W = 3;

  typedef enum logic [IMMSRC_W-1:0] {
    IMMSRC_I_TYPE = 3'd0,
    IMMSRC_S_TYPE = 3'd1,
    IMMSRC_B_TYPE = 3'd2,
    IMMSRC_U_TYPE = 3'd3,
    IMMSRC_J_TYPE = 3'd4,
    IMMSRC_Z_TYPE = 3'd5,
    IMMSRC_SHAMT  = 3'd6
  } ImmSrc_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // A empty, B empty
    ST_ONE   = 2'd1,  // A holds the output, B empty
    ST_FULL  = 2'd2   // A holds the output, B holds the next entry
  } stage_state_t;

endpackage

// File: rtl/imm_extend_stage_if.sv
// Upstream/downstream bundle of the immediate-extend stage.
//   in_*  : decode -> stage (valid/ready, instruction, PC, selector)
//   out_* : stage -> execute (valid/ready, immediate, target, PC, illegal)
// slave is the stage's view; master is the surrounding pipeline's view.
interface imm_extend_stage_if
  import imm_extend_stage_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  ImmSrc_t         in_immsrc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_immsrc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, in_immsrc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_pc, out_illegal
  );

endinterface

// File: rtl/imm_extend_stage_decode.sv
// imm_decode: combinational immediate generator.
//   instr   in  32   : instruction word (opcode bits [6:0] not used)
//   immsrc  in       : format selector
//   imm     out XLEN : extended immediate, 0 for an undefined selector
//   illegal out 1    : selector was undefined
module imm_decode
  import imm_extend_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  ImmSrc_t         immsrc,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Every format is first built as a 32-bit value already sign-extended to
  // bit 31. Z and SHAMT have bit 31 clear, so one final sign extension to
  // XLEN handles every format, including U on RV64.
  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (immsrc)
      IMMSRC_I_TYPE: raw = {{20{instr[31]}}, instr[31:20]};
      IMMSRC_S_TYPE: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMMSRC_B_TYPE: raw = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
      IMMSRC_J_TYPE: raw = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
      IMMSRC_U_TYPE: raw = {instr[31:12], 12'b0};
      IMMSRC_Z_TYPE: raw = {27'b0, instr[19:15]};
      // RV64 shift amounts are 6 bits wide; RV32 ignores instr[25].
      IMMSRC_SHAMT:  raw = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
      default:       illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate generation between decode and
// execute, with a two-entry output/skid buffer.
//   clk, resetn : clock; asynchronous active-low reset
//   flush       : discards both held entries on the next edge and blocks
//                 any accept in the same cycle
//   bus         : in_* upstream handshake/payload, out_* downstream result
// Entry A drives the outputs; entry B catches the one instruction accepted
// while A is stalled. in_ready depends only on registered state.
module imm_extend_stage
  import imm_extend_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  imm_extend_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  stage_state_t    state_q, state_d;
  entry_t          a_q, a_d, b_q, b_d;
  entry_t          incoming;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            in_ready, out_valid, accept, take;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.in_instr),
    .immsrc  (bus.in_immsrc),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // The adder sits before register A so the target leaves with the entry.
  always_comb begin
    incoming.imm     = dec_imm;
    incoming.pc      = bus.in_pc;
    incoming.target  = bus.in_pc + dec_imm;
    incoming.illegal = dec_illegal;
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid && in_ready;
  assign take      = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (flush) begin
      state_d = ST_EMPTY;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            a_d     = incoming;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            a_d = incoming;
          end else if (accept) begin
            b_d     = incoming;
            state_d = ST_FULL;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (take) begin
            a_d     = b_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  // NOTE: the entry registers are reset as well because the outputs they
  // drive must read as zero while the stage is held in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_imm     = a_q.imm;
  assign bus.out_target  = a_q.target;
  assign bus.out_pc      = a_q.pc;
  assign bus.out_illegal = a_q.illegal;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Testbench for imm_extend_stage: one RV32 and one RV64 instance, driven
// from vector tables; a per-instance scoreboard queue holds the expected
// results of accepted instructions and is compared whenever out_valid is
// high (so held outputs are re-checked every stalled cycle).
module tb_imm_extend_stage;
  import imm_extend_stage_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic flush  = 1'b0;

  always #5 clk = ~clk;

  imm_extend_stage_if #(.XLEN(32)) ifc32 ();
  imm_extend_stage_if #(.XLEN(64)) ifc64 ();

  imm_extend_stage #(.XLEN(32)) dut32 (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (ifc32.slave)
  );

  imm_extend_stage #(.XLEN(64)) dut64 (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (ifc64.slave)
  );

  typedef struct {
    ImmSrc_t     sel;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] target;
    logic        ill;
  } exp_t;

  vec_t tab32 [12];
  vec_t tab64 [8];
  vec_t cur32, cur64;
  exp_t q32 [$];
  exp_t q64 [$];
  exp_t e32, e64;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e.imm    = v.imm;
    e.pc     = v.pc;
    e.target = v.pc + v.imm;
    e.ill    = v.ill;
    return e;
  endfunction

  // Scoreboard, RV32 instance.
  always @(negedge clk) begin
    if (!resetn) begin
      q32.delete();
    end else begin
      if (ifc32.out_valid) begin
        if (q32.size() == 0) begin
          check("out_valid32_unexpected", 64'(ifc32.out_valid), 64'd0);
        end else begin
          e32 = q32[0];
          check("imm32",     64'(ifc32.out_imm),     64'(e32.imm[31:0]));
          check("target32",  64'(ifc32.out_target),  64'(e32.target[31:0]));
          check("pc32",      64'(ifc32.out_pc),      64'(e32.pc[31:0]));
          check("illegal32", 64'(ifc32.out_illegal), 64'(e32.ill));
          if (ifc32.out_ready && !flush) void'(q32.pop_front());
        end
      end
      if (flush) q32.delete();
      else if (ifc32.in_valid && ifc32.in_ready) q32.push_back(expect_of(cur32));
    end
  end

  // Scoreboard, RV64 instance.
  always @(negedge clk) begin
    if (!resetn) begin
      q64.delete();
    end else begin
      if (ifc64.out_valid) begin
        if (q64.size() == 0) begin
          check("out_valid64_unexpected", 64'(ifc64.out_valid), 64'd0);
        end else begin
          e64 = q64[0];
          check("imm64",     ifc64.out_imm,          e64.imm);
          check("target64",  ifc64.out_target,       e64.target);
          check("pc64",      ifc64.out_pc,           e64.pc);
          check("illegal64", 64'(ifc64.out_illegal), 64'(e64.ill));
          if (ifc64.out_ready && !flush) void'(q64.pop_front());
        end
      end
      if (flush) q64.delete();
      else if (ifc64.in_valid && ifc64.in_ready) q64.push_back(expect_of(cur64));
    end
  end

  // Present one instruction (w=0: RV32, w=1: RV64) and hold it until the
  // stage takes it; returns 1 time unit after the accepting edge.
  task automatic send(input int w, input vec_t v);
    bit rdy;
    bit done = 1'b0;
    if (w == 0) begin
      cur32           = v;
      ifc32.in_instr  = v.instr;
      ifc32.in_pc     = v.pc[31:0];
      ifc32.in_immsrc = v.sel;
      ifc32.in_valid  = 1'b1;
    end else begin
      cur64           = v;
      ifc64.in_instr  = v.instr;
      ifc64.in_pc     = v.pc;
      ifc64.in_immsrc = v.sel;
      ifc64.in_valid  = 1'b1;
    end
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy  = (w == 0) ? ifc32.in_ready : ifc64.in_ready;
      done = rdy && !flush;
    end
    if (done) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instance %0d instr %h never accepted", w, v.instr);
    end
    if (w == 0) ifc32.in_valid = 1'b0;
    else        ifc64.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid32"}, 64'(ifc32.out_valid),   64'd0);
    check({tag, "_in_ready32"},  64'(ifc32.in_ready),    64'd1);
    check({tag, "_imm32"},       64'(ifc32.out_imm),     64'd0);
    check({tag, "_target32"},    64'(ifc32.out_target),  64'd0);
    check({tag, "_pc32"},        64'(ifc32.out_pc),      64'd0);
    check({tag, "_illegal32"},   64'(ifc32.out_illegal), 64'd0);
    check({tag, "_out_valid64"}, 64'(ifc64.out_valid),   64'd0);
    check({tag, "_in_ready64"},  64'(ifc64.in_ready),    64'd1);
  endtask

  initial begin
    int   c0;
    vec_t seq [3];
    vec_t bad;

    tab32[0]  = '{IMMSRC_I_TYPE, 32'hFFF00093, 64'h100,  64'hFFFFFFFF, 1'b0};
    tab32[1]  = '{IMMSRC_B_TYPE, 32'hFE000EE3, 64'h0,    64'hFFFFFFFC, 1'b0};
    tab32[2]  = '{IMMSRC_S_TYPE, 32'h00112423, 64'h200,  64'h8,        1'b0};
    tab32[3]  = '{IMMSRC_J_TYPE, 32'h0080006F, 64'h1000, 64'h8,        1'b0};
    tab32[4]  = '{IMMSRC_U_TYPE, 32'h12345037, 64'h10,   64'h12345000, 1'b0};
    tab32[5]  = '{IMMSRC_Z_TYPE, 32'h3400D073, 64'h20,   64'h1,        1'b0};
    tab32[6]  = '{IMMSRC_SHAMT,  32'h03F09093, 64'h24,   64'h1F,       1'b0};
    tab32[7]  = '{ImmSrc_t'(3'd7), 32'hFFFFFFFF, 64'h28, 64'h0,        1'b1};
    tab32[8]  = '{IMMSRC_I_TYPE, 32'h80000013, 64'h0,    64'hFFFFF800, 1'b0};
    tab32[9]  = '{IMMSRC_U_TYPE, 32'h800000B7, 64'h4,    64'h80000000, 1'b0};
    tab32[10] = '{IMMSRC_S_TYPE, 32'hFE112E23, 64'h30,   64'hFFFFFFFC, 1'b0};
    tab32[11] = '{IMMSRC_J_TYPE, 32'hFFDFF06F, 64'h34,   64'hFFFFFFFC, 1'b0};

    tab64[0] = '{IMMSRC_U_TYPE, 32'h800000B7, 64'h0,   64'hFFFFFFFF80000000, 1'b0};
    tab64[1] = '{IMMSRC_SHAMT,  32'h03F09093, 64'h8,   64'h3F,               1'b0};
    tab64[2] = '{IMMSRC_Z_TYPE, 32'h3400D073, 64'h10,  64'h1,                1'b0};
    tab64[3] = '{IMMSRC_I_TYPE, 32'hFFF00093, 64'h100, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tab64[4] = '{IMMSRC_B_TYPE, 32'hFE000EE3, 64'h0,   64'hFFFFFFFFFFFFFFFC, 1'b0};
    tab64[5] = '{IMMSRC_I_TYPE, 32'h01000093, 64'hFFFFFFFFFFFFFFF0, 64'h10,  1'b0};
    tab64[6] = '{ImmSrc_t'(3'd7), 32'hFFFFFFFF, 64'h40, 64'h0,               1'b1};
    tab64[7] = '{IMMSRC_U_TYPE, 32'h12345037, 64'h0,   64'h12345000,         1'b0};

    seq[0] = '{IMMSRC_I_TYPE, 32'h00100093, 64'h40, 64'h1,        1'b0};
    seq[1] = '{IMMSRC_I_TYPE, 32'h00200113, 64'h44, 64'h2,        1'b0};
    seq[2] = '{IMMSRC_I_TYPE, 32'hFFE00193, 64'h48, 64'hFFFFFFFE, 1'b0};
    bad    = tab32[7];

    ifc32.in_valid = 1'b0; ifc32.in_instr = '0; ifc32.in_pc = '0;
    ifc32.in_immsrc = IMMSRC_I_TYPE; ifc32.out_ready = 1'b1;
    ifc64.in_valid = 1'b0; ifc64.in_instr = '0; ifc64.in_pc = '0;
    ifc64.in_immsrc = IMMSRC_I_TYPE; ifc64.out_ready = 1'b1;

    // Reset state.
    #1 resetn = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Full-rate stream, no back-pressure: one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < 12; i++) send(0, tab32[i]);
    check("throughput32", 64'(cyc - c0), 64'd12);
    drain();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(1, tab64[i]);
    check("throughput64", 64'(cyc - c0), 64'd8);
    drain();

    // Random back-pressure and idle gaps; ordering checked by the scoreboard.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          send(0, tab32[i % 12]);
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #1;
        end
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1 ifc32.out_ready = 1'($urandom_range(0, 1));
        end
        ifc32.out_ready = 1'b1;
      end
    join
    drain();

    // Back-pressure: two accepts fill A and B, the third waits for a take.
    ifc32.out_ready = 1'b0;
    send(0, seq[0]);
    send(0, seq[1]);
    check("in_ready_full", 64'(ifc32.in_ready), 64'd0);
    check("out_valid_full", 64'(ifc32.out_valid), 64'd1);
    ifc32.out_ready = 1'b1;
    c0 = cyc;
    send(0, seq[2]);
    check("skid_stall_cycles", 64'(cyc - c0), 64'd2);
    drain();

    // Flush while full, with a simultaneous valid input.
    ifc32.out_ready = 1'b0;
    send(0, tab32[2]);
    send(0, tab32[3]);
    cur32           = tab32[4];
    ifc32.in_instr  = tab32[4].instr;
    ifc32.in_pc     = tab32[4].pc[31:0];
    ifc32.in_immsrc = tab32[4].sel;
    ifc32.in_valid  = 1'b1;
    flush           = 1'b1;
    @(posedge clk);
    #1;
    flush          = 1'b0;
    ifc32.in_valid = 1'b0;
    check("flush_out_valid", 64'(ifc32.out_valid), 64'd0);
    check("flush_in_ready",  64'(ifc32.in_ready),  64'd1);
    check("flush_imm",       64'(ifc32.out_imm),   64'd0);
    ifc32.out_ready = 1'b1;
    drain();
    check("flush_input_dropped", 64'(ifc32.out_valid), 64'd0);

    // Illegal selector held in A while FULL, then asynchronous reset.
    ifc32.out_ready = 1'b0;
    send(0, bad);
    send(0, tab32[0]);
    check("illegal_held", 64'(ifc32.out_illegal), 64'd1);
    @(posedge clk);
    #2 resetn = 1'b0;
    q32.delete();
    q64.delete();
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    ifc32.out_ready = 1'b1;

    // Recovery after reset.
    send(0, tab32[1]);
    send(1, tab64[0]);
    drain();
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q64_drained", 64'(q64.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
